// File: rtl/ula_16_bits_seq.sv
// ula_16_bits_seq
//   Runs one WIDTH-bit 74181-style ALU operation as WIDTH/8 consecutive
//   8-bit passes through a shared external ula_8_bits datapath, LSB slice
//   first, rippling each slice's carry into the next. The assembled result
//   and combined flags are returned over a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   in_valid / in_ready        command handshake
//   a, b, s, m, c_in           command: operands, function select, mode, carry in
//   out_valid / out_ready      result handshake
//   f, a_eq_b, c_out,
//   overflow, p, g             full-width result and flags
//   alu_a, alu_b, alu_s,
//   alu_m, alu_c_in            slice command driven to ula_8_bits
//   alu_f, alu_a_eq_b,
//   alu_c_out, alu_p, alu_g    slice result returned from ula_8_bits
module ula_16_bits_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             a_eq_b,
  output logic             c_out,
  output logic             overflow,
  output logic             p,
  output logic             g,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_c_in,
  input  logic [7:0]       alu_f,
  input  logic             alu_a_eq_b,
  input  logic             alu_c_out,
  input  logic             alu_p,
  input  logic             alu_g
);

  localparam int N  = WIDTH / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q, eq_q, p_q, g_q;
  logic [CW-1:0]    cnt;
  logic             last_slice;

  assign last_slice = (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Command latch and per-slice accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      f_q     <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            f_q     <= '0;
            carry_q <= c_in;
            eq_q    <= 1'b1;
            p_q     <= 1'b1;
            g_q     <= 1'b0;
            cnt     <= '0;
          end
        end
        RUN: begin
          f_q[{cnt, 3'b000} +: 8] <= alu_f;
          carry_q <= alu_c_out;
          eq_q    <= eq_q & alu_a_eq_b;
          // Current slice is the more significant group relative to the
          // accumulated lower slices.
          g_q     <= alu_g | (alu_p & g_q);
          p_q     <= p_q & alu_p;
          cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = '0;
    alu_m     = 1'b0;
    alu_c_in  = 1'b0;
    overflow  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        alu_a    = a_q[{cnt, 3'b000} +: 8];
        alu_b    = b_q[{cnt, 3'b000} +: 8];
        alu_s    = s_q;
        alu_m    = m_q;
        alu_c_in = carry_q;
      end
      DONE: begin
        out_valid = 1'b1;
        if (!m_q) begin
          if (s_q == 4'b1001)
            overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (f_q[WIDTH-1] != a_q[WIDTH-1]);
          else if (s_q == 4'b0110)
            overflow = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (f_q[WIDTH-1] == b_q[WIDTH-1]);
        end
      end
      default: ;
    endcase
  end

  assign f      = f_q;
  assign a_eq_b = eq_q;
  assign c_out  = carry_q;
  assign p      = p_q;
  assign g      = g_q;

endmodule
